// File: rtl/cdb_rr_arbiter.sv
// cdb_rr_arbiter: round-robin arbiter steering one of N_REQS result producers into a registered CDB slot
module cdb_rr_arbiter #(
    parameter int WIDTH = 32,
    parameter int N_REQS = 4,
    localparam int PTR_W = $clog2(N_REQS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_REQS-1:0]              req_valid,
    input  logic [N_REQS-1:0][WIDTH-1:0]   req_data,
    output logic [N_REQS-1:0]              req_ready,
    output logic [N_REQS-1:0]              grant,
    output logic                           out_valid,
    output logic [WIDTH-1:0]               out_data,
    output logic [N_REQS-1:0]              out_src,
    input  logic                           out_ready
);
    logic [PTR_W-1:0]  prio_q, prio_d, nxt_ptr, idx;
    logic              out_valid_q, out_valid_d, load_en, xfer;
    logic [WIDTH-1:0]  out_data_q, out_data_d, mux_data;
    logic [N_REQS-1:0] out_src_q, out_src_d;

    // Scanning from the lowest priority upward lets the last hit be the winner.
    always_comb begin
        grant = '0;
        nxt_ptr = prio_q;
        idx = '0;
        for (int i = N_REQS - 1; i >= 0; i--) begin
            idx = PTR_W'((int'(prio_q) + i) % N_REQS);
            if (req_valid[idx]) begin
                grant = N_REQS'(1) << idx;
                nxt_ptr = PTR_W'((int'(idx) + 1) % N_REQS);
            end
        end
    end

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < N_REQS; i++) mux_data |= req_data[i] & {WIDTH{grant[i]}};
    end

    assign load_en   = ~out_valid_q | out_ready;
    assign req_ready = grant & {N_REQS{load_en}};
    assign xfer      = |req_ready;

    always_comb begin
        out_valid_d = xfer | (out_valid_q & ~out_ready);
        out_data_d  = xfer ? mux_data : out_data_q;
        out_src_d   = xfer ? grant : out_src_q;
        prio_d      = xfer ? nxt_ptr : prio_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            prio_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            prio_q      <= prio_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
    a_src_onehot:    assert property (@(posedge clk) disable iff (!rst_n) out_valid_q |-> $onehot(out_src_q));
    a_ready_valid:   assert property (@(posedge clk) disable iff (!rst_n) (req_ready & ~req_valid) == '0);
endmodule

// File: doc/cdb_rr_arbiter.md
Name: cdb_rr_arbiter

Overview:
- Round-robin arbiter sharing one result bus (CDB write slot) among N_REQS producers, e.g. functional units and the load unit.
- Each cycle it computes a one-hot grant, steers the granted payload through an internal one-hot mux, and registers the result into a single-entry output stage with valid/ready handshake.
- Sits between functional-unit result ports and the CDB broadcast consumers (ROB, issue queues, bypass).

Parameters:
- WIDTH, 32, payload width in bits.
- N_REQS, 4, number of requesters; must be ≥2.
- PTR_W, $clog2(N_REQS), priority pointer width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  N_REQS  per-requester valid.
- req_data  in  N_REQS x WIDTH  per-requester payload, packed 2-D [N_REQS-1:0][WIDTH-1:0].
- req_ready  out  N_REQS  per-requester accept; a transfer occurs when req_valid[i] & req_ready[i].
- grant  out  N_REQS  combinational one-hot (or zero) grant for the current cycle.
- out_valid  out  1  output stage holds a valid entry.
- out_data  out  WIDTH  registered payload.
- out_src  out  N_REQS  registered one-hot source ID of out_data.
- out_ready  in  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (rst_n=0 at clock edge): out_valid=0, out_data=0, out_src=0, prio_ptr=0. Reset overrides any handshake in the same cycle; an in-flight entry is dropped.
- load_en = ~out_valid | out_ready. This is the bypass-ready form; a full stage accepts a new entry in the same cycle it drains.
- Grant: scan indices prio_ptr, prio_ptr+1, ... mod N_REQS. grant[k]=1 for the first k with req_valid[k]=1. grant=0 when no req_valid.
- grant is computed regardless of load_en.
- req_ready = grant & {N_REQS{load_en}}. At most one requester transfers per cycle.
- req_ready depends combinationally on out_ready and req_valid. Requesters must not make req_valid depend on req_ready.
- On transfer (|req_ready and load_en):
  - out_data <= req_data[k]
  - out_src <= grant
  - out_valid <= 1
  - prio_ptr <= (k+1) mod N_REQS, wrapping from N_REQS-1 to 0.
- No transfer and out_ready=1: out_valid <= 0. out_data and out_src hold their values (don't-care).
- No transfer and out_ready=0: all registers hold.
- prio_ptr changes only on a transfer. A stalled grant does not rotate priority.
- Backpressure:
  - While out_valid=1 and out_ready=0, out_data and out_src are stable and req_ready=0.
  - grant may still change if req_valid changes.
- Latency: one cycle from request transfer to out_valid.
- Throughput: one entry per cycle with out_ready held at 1.
- Fairness: a continuously asserting requester is granted within N_REQS transfers.
- Mux: the internal one-hot mux is an AND-OR over grant. Output is 0 when grant=0.
- Assertions:
  - grant is one-hot or zero ($onehot0).
  - out_src is one-hot whenever out_valid=1.
  - No req_ready bit is set without the matching req_valid bit.

Test Plan:
- Reset/idle: hold rst_n=0 for 2 cycles, then release with req_valid=0 -> out_valid=0, out_data=0, out_src=0, grant=0, req_ready=0.
- Single requester: req_valid=4'b0100, req_data[2]=32'hDEAD_BEEF, out_ready=1 -> grant=0100 and req_ready=0100 the same cycle. Next cycle out_valid=1, out_data=DEADBEEF, out_src=0100; prio_ptr=3.
- Round-robin and wrap: all four req_valid held high, out_ready=1, from reset -> grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles. out_src follows one cycle later.
- Backpressure: out_valid=1 with out_data=32'h11, out_ready=0 for 3 cycles, req_valid=1111 -> req_ready=0, out_data stays 32'h11, prio_ptr frozen. When out_ready rises, the next pending requester transfers the same cycle.
- Simultaneous drain and load: out_valid=1, out_ready=1, req_valid=0010 -> req_ready=0010 and out_valid stays 1 with the new data next cycle. Repeat with req_valid=0 -> out_valid=0 next cycle.
- Reset mid-operation: out_valid=1 and prio_ptr=2, then pulse rst_n=0 for one cycle with req_valid=1111 -> out_valid=0, prio_ptr=0. First post-reset grant is 0001.
